// File: rtl/cpu_seq_pkg.sv
// Shared types and field layout for the cpu_seq_ctrl multi-cycle controller.
// Optional CPU_SEQ_PERF_EN adds retired/cycle counters (see cpu_seq_ctrl).
package cpu_seq_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int REG_ADDR_W  = 2;
  localparam int IMM_W       = 8;

  localparam int OP_MSB   = 19;
  localparam int OP_LSB   = 18;
  localparam int X1_MSB   = 17;
  localparam int X1_LSB   = 16;
  localparam int X2_MSB   = 15;
  localparam int X2_LSB   = 14;
  localparam int X3_MSB   = 13;
  localparam int X3_LSB   = 12;
  localparam int IMM_MSB  = 11;
  localparam int IMM_LSB  = 4;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    RTYPE   = 2'b01,
    LOAD_R  = 2'b10,
    STORE_R = 2'b11
  } op_t;

  // Only R-type has a func field; anything beyond SUB is undefined.
  function automatic logic is_illegal(input op_t op, input logic [3:0] func);
    return (op == RTYPE) && (func > FUNC_SUB);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Instruction handshake plus datapath control bundle for cpu_seq_ctrl.
// With CPU_SEQ_PERF_EN defined the bundle also carries the perf counters.
interface cpu_seq_ctrl_if;
  import cpu_seq_pkg::*;

  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_ready;
  logic [REG_ADDR_W-1:0]  rs_a;
  logic [REG_ADDR_W-1:0]  rs_b;
  logic [REG_ADDR_W-1:0]  rd;
  logic                   rf_we;
  logic                   alu_op;
  logic                   alu_src_imm;
  logic [IMM_W-1:0]       imm;
  logic                   dmem_re;
  logic                   dmem_we;
  logic                   wb_sel_mem;
  logic                   done;
  logic                   illegal;
`ifdef CPU_SEQ_PERF_EN
  logic [15:0]            retired_cnt;
  logic [15:0]            cycle_cnt;
`endif

  // master = instruction source / datapath side, slave = the controller
  modport master (
    output instr_valid, instr,
    input  instr_ready, rs_a, rs_b, rd, rf_we, alu_op, alu_src_imm, imm,
           dmem_re, dmem_we, wb_sel_mem, done, illegal
`ifdef CPU_SEQ_PERF_EN
    , input retired_cnt, cycle_cnt
`endif
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, rs_a, rs_b, rd, rf_we, alu_op, alu_src_imm, imm,
           dmem_re, dmem_we, wb_sel_mem, done, illegal
`ifdef CPU_SEQ_PERF_EN
    , output retired_cnt, cycle_cnt
`endif
  );

endinterface

// File: rtl/cpu_seq_decode.sv
// Combinational field extraction and legality check for a latched instruction.
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] i_word,
  output op_t                    o_op,
  output logic [REG_ADDR_W-1:0]  o_x1,
  output logic [REG_ADDR_W-1:0]  o_x2,
  output logic [REG_ADDR_W-1:0]  o_x3,
  output logic [IMM_W-1:0]       o_imm,
  output logic                   o_sub,
  output logic                   o_illegal
);

  logic [3:0] w_func;

  assign o_op      = op_t'(i_word[OP_MSB:OP_LSB]);
  assign o_x1      = i_word[X1_MSB:X1_LSB];
  assign o_x2      = i_word[X2_MSB:X2_LSB];
  assign o_x3      = i_word[X3_MSB:X3_LSB];
  assign o_imm     = i_word[IMM_MSB:IMM_LSB];
  assign w_func    = i_word[FUNC_MSB:FUNC_LSB];
  assign o_sub     = w_func[0];
  assign o_illegal = is_illegal(o_op, w_func);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control FSM: IDLE -> DECODE -> EXEC -> MEM -> WB for the simple CPU.
// Optional macro CPU_SEQ_PERF_EN adds retired_cnt/cycle_cnt counters.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  cpu_seq_ctrl_if.slave  bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [REG_ADDR_W-1:0]  r_rs_a, r_rs_b, r_rd;
  logic [IMM_W-1:0]       r_imm;
  logic [REG_ADDR_W-1:0]  w_rs_a, w_rs_b, w_rd;
  logic [IMM_W-1:0]       w_imm;
  logic                   w_ready, w_rf_we, w_alu_op, w_alu_src_imm;
  logic                   w_dmem_re, w_dmem_we, w_wb_sel_mem, w_done, w_illegal;

  op_t                    w_op;
  logic [REG_ADDR_W-1:0]  w_x1, w_x2, w_x3;
  logic [IMM_W-1:0]       w_fimm;
  logic                   w_sub, w_bad;

  cpu_seq_decode u_decode (
    .i_word    (r_instr),
    .o_op      (w_op),
    .o_x1      (w_x1),
    .o_x2      (w_x2),
    .o_x3      (w_x3),
    .o_imm     (w_fimm),
    .o_sub     (w_sub),
    .o_illegal (w_bad)
  );

  // Address/imm registers capture whatever was driven so outputs hold in other states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_rs_a  <= '0;
      r_rs_b  <= '0;
      r_rd    <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_next;
      r_rs_a  <= w_rs_a;
      r_rs_b  <= w_rs_b;
      r_rd    <= w_rd;
      r_imm   <= w_imm;
      if (bus.instr_valid && w_ready) begin
        r_instr <= bus.instr;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_rs_a        = r_rs_a;
    w_rs_b        = r_rs_b;
    w_rd          = r_rd;
    w_imm         = r_imm;
    w_ready       = 1'b0;
    w_rf_we       = 1'b0;
    w_alu_op      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_dmem_re     = 1'b0;
    w_dmem_we     = 1'b0;
    w_wb_sel_mem  = 1'b0;
    w_done        = 1'b0;
    w_illegal     = 1'b0;

    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) begin
          w_next = DECODE;
        end
      end

      DECODE: begin
        w_rs_a = w_x2;
        w_rs_b = w_x3;
        w_rd   = w_x1;
        w_imm  = w_fimm;
        if (w_op == NOP) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_bad) begin
          w_done    = 1'b1;
          w_illegal = 1'b1;
          w_next    = IDLE;
        end else begin
          w_next = EXEC;
        end
      end

      EXEC: begin
        w_rs_a = w_x2;
        if (w_op == RTYPE) begin
          w_rs_b   = w_x3;
          w_alu_op = w_sub;
          w_next   = WB;
        end else begin
          w_imm         = w_fimm;
          w_alu_src_imm = 1'b1;
          w_next        = MEM;
        end
      end

      // Only loads and stores reach MEM; a store retires here with X1 as store data.
      MEM: begin
        if (w_op == LOAD_R) begin
          w_dmem_re = 1'b1;
          w_next    = WB;
        end else begin
          w_dmem_we = 1'b1;
          w_rs_b    = w_x1;
          w_done    = 1'b1;
          w_next    = IDLE;
        end
      end

      WB: begin
        w_rf_we      = 1'b1;
        w_rd         = w_x1;
        w_wb_sel_mem = (w_op == LOAD_R);
        w_done       = 1'b1;
        w_next       = IDLE;
      end

      default: w_next = IDLE;
    endcase
  end

  assign bus.instr_ready = w_ready;
  assign bus.rs_a        = w_rs_a;
  assign bus.rs_b        = w_rs_b;
  assign bus.rd          = w_rd;
  assign bus.imm         = w_imm;
  assign bus.rf_we       = w_rf_we;
  assign bus.alu_op      = w_alu_op;
  assign bus.alu_src_imm = w_alu_src_imm;
  assign bus.dmem_re     = w_dmem_re;
  assign bus.dmem_we     = w_dmem_we;
  assign bus.wb_sel_mem  = w_wb_sel_mem;
  assign bus.done        = w_done;
  assign bus.illegal     = w_illegal;

`ifdef CPU_SEQ_PERF_EN
  logic [15:0] r_retired_cnt;
  logic [15:0] r_cycle_cnt;

  // Both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= '0;
      r_cycle_cnt   <= '0;
    end else begin
      if (w_done) begin
        r_retired_cnt <= r_retired_cnt + 16'd1;
      end
      if (r_state != IDLE) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
    end
  end

  assign bus.retired_cnt = r_retired_cnt;
  assign bus.cycle_cnt   = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized self-checking bench for cpu_seq_ctrl against a per-instruction timing model.
module tb_cpu_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   modelRetired;
  int   modelCycles;

  cpu_seq_ctrl_if bus();

  cpu_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake-to-done latency straight from the instruction's op/func.
  function automatic int expLat(input logic [19:0] w);
    case (w[19:18])
      2'b00:   return 1;
      2'b01:   return (w[3:0] > 4'd1) ? 1 : 3;
      2'b11:   return 3;
      default: return 4;
    endcase
  endfunction

  task automatic checkPerf(input string tag);
`ifdef CPU_SEQ_PERF_EN
    checks++;
    if (bus.retired_cnt !== 16'(modelRetired)) begin
      errors++;
      $display("[TB] FAIL %s retired_cnt got=%0d exp=%0d", tag, bus.retired_cnt, 16'(modelRetired));
    end
    checks++;
    if (bus.cycle_cnt !== 16'(modelCycles)) begin
      errors++;
      $display("[TB] FAIL %s cycle_cnt got=%0d exp=%0d", tag, bus.cycle_cnt, 16'(modelCycles));
    end
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  // Caller must be positioned at a negedge; returns positioned at the negedge after done.
  task automatic runInstr(input logic [19:0] w, input int idleGap);
    logic [1:0] op, x1, x2, x3;
    logic [7:0] immF;
    logic       isR, isL, isS, expIll;
    int         lat, nRf, nWe, nRe, nDone, nIll;
    op = w[19:18]; x1 = w[17:16]; x2 = w[15:14]; x3 = w[13:12]; immF = w[11:4];
    lat = expLat(w);
    expIll = (op == 2'b01) && (w[3:0] > 4'd1);
    isR = (op == 2'b01) && !expIll;
    isL = (op == 2'b10);
    isS = (op == 2'b11);
    nRf = 0; nWe = 0; nRe = 0; nDone = 0; nIll = 0;

    for (int g = 0; g < idleGap; g++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle ready/done got=%b/%b exp=1/0", bus.instr_ready, bus.done);
      end
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_before got=%b exp=1", bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 20'($urandom);

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat) begin
        nRf   += int'(bus.rf_we);
        nWe   += int'(bus.dmem_we);
        nRe   += int'(bus.dmem_re);
        nDone += int'(bus.done);
        nIll  += int'(bus.illegal);
        checks++;
        if (bus.instr_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_ready w=%05h c=%0d got=%b exp=0", w, c, bus.instr_ready);
        end
      end
      if (c == 1) begin
        checks++;
        if (bus.rs_a !== x2 || bus.rd !== x1 || bus.imm !== immF) begin
          errors++;
          $display("[TB] FAIL decode_fields w=%05h got=%0d/%0d/%0h exp=%0d/%0d/%0h",
                   w, bus.rs_a, bus.rd, bus.imm, x2, x1, immF);
        end
      end
      if (c == 2 && (isR || isL || isS)) begin
        checks++;
        if (bus.rs_a !== x2 || bus.alu_src_imm !== !isR || bus.alu_op !== (isR && w[0])
            || bus.imm !== immF || (isR && bus.rs_b !== x3)) begin
          errors++;
          $display("[TB] FAIL exec w=%05h rs_a/rs_b/op/src/imm got=%0d/%0d/%b/%b/%0h exp=%0d/%0d/%b/%b/%0h",
                   w, bus.rs_a, bus.rs_b, bus.alu_op, bus.alu_src_imm, bus.imm,
                   x2, x3, isR && w[0], !isR, immF);
        end
      end
      if (c == 3 && isL) begin
        checks++;
        if (bus.dmem_re !== 1'b1) begin
          errors++;
          $display("[TB] FAIL load_mem_re w=%05h got=%b exp=1", w, bus.dmem_re);
        end
      end
      if (c == lat) begin
        checks++;
        if (bus.done !== 1'b1 || bus.illegal !== expIll) begin
          errors++;
          $display("[TB] FAIL retire w=%05h done/illegal got=%b/%b exp=1/%b", w, bus.done, bus.illegal, expIll);
        end
        if (isR || isL) begin
          checks++;
          if (bus.rf_we !== 1'b1 || bus.rd !== x1 || bus.wb_sel_mem !== isL) begin
            errors++;
            $display("[TB] FAIL writeback w=%05h we/rd/sel got=%b/%0d/%b exp=1/%0d/%b",
                     w, bus.rf_we, bus.rd, bus.wb_sel_mem, x1, isL);
          end
        end
        if (isS) begin
          checks++;
          if (bus.dmem_we !== 1'b1 || bus.rs_b !== x1) begin
            errors++;
            $display("[TB] FAIL store w=%05h we/rs_b got=%b/%0d exp=1/%0d", w, bus.dmem_we, bus.rs_b, x1);
          end
        end
      end
      if (c == lat + 1) begin
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ready_after w=%05h ready/done got=%b/%b exp=1/0", w, bus.instr_ready, bus.done);
        end
      end
    end

    checks++;
    if (nRf !== int'(isR || isL) || nWe !== int'(isS) || nRe !== int'(isL)
        || nDone !== 1 || nIll !== int'(expIll)) begin
      errors++;
      $display("[TB] FAIL strobe_counts w=%05h rf/we/re/done/ill got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/1/%0d",
               w, nRf, nWe, nRe, nDone, nIll, int'(isR || isL), int'(isS), int'(isL), int'(expIll));
    end
    modelRetired++;
    modelCycles += lat;
    checkPerf("perf_after_instr");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.illegal !== 1'b0
        || bus.rf_we !== 1'b0 || bus.dmem_we !== 1'b0 || bus.dmem_re !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl ready/done/ill/rfwe/dwe/dre got=%b/%b/%b/%b/%b/%b exp=1/0/0/0/0/0",
               bus.instr_ready, bus.done, bus.illegal, bus.rf_we, bus.dmem_we, bus.dmem_re);
    end
    checks++;
    if (bus.rs_a !== 2'd0 || bus.rs_b !== 2'd0 || bus.rd !== 2'd0 || bus.imm !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr rs_a/rs_b/rd/imm got=%0d/%0d/%0d/%0h exp=0/0/0/0",
               bus.rs_a, bus.rs_b, bus.rd, bus.imm);
    end
    modelRetired = 0;
    modelCycles  = 0;
    checkPerf("perf_reset");
    rst = 1'b0;
  endtask

  task automatic test_directed();
    runInstr(20'b01000111000000000000, 1);
    runInstr(20'b01110010000000000001, 1);
    runInstr(20'b11011000000011110000, 1);
    runInstr(20'b10111000000011110000, 1);
  endtask

  task automatic test_illegal_nop();
    runInstr(20'b01000111000000000101, 1);
    runInstr(20'h00000, 1);
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = 20'b11011000000011110000;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dmem_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_mem_we got=%b exp=1", bus.dmem_we);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dmem_we !== 1'b0 || bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.rs_b !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset we/ready/done/rs_b got=%b/%b/%b/%0d exp=0/1/0/0",
               bus.dmem_we, bus.instr_ready, bus.done, bus.rs_b);
    end
    @(negedge clk);
    rst = 1'b0;
    modelRetired = 0;
    modelCycles  = 0;
    checkPerf("perf_after_abort");
    runInstr(20'b01000111000000000000, 0);
  endtask

  task automatic test_back_to_back();
    runInstr(20'b10111000000011110000, 0);
    runInstr(20'b11011000000011110000, 0);
    runInstr(20'h00000, 0);
    runInstr(20'b01110010000000000001, 0);
  endtask

  task automatic test_random();
    logic [19:0] w;
    for (int i = 0; i < 60; i++) begin
      w = 20'($urandom);
      if ($urandom_range(0, 1) == 0) w[3:1] = 3'b000;
      runInstr(w, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelRetired = 0;
    modelCycles = 0;
    test_reset();
    test_directed();
    test_illegal_nop();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle control FSM for the simple CPU datapath (4-entry regfile, 8-bit ALU, 32-entry data memory).
- Accepts one 20-bit instruction per valid/ready handshake, latches it, and sequences the regfile, ALU and data-memory strobes over DECODE/EXEC/MEM/WB.
- Sits between the instruction source and the datapath; generates every datapath control signal.

Parameters:
INSTR_WIDTH, 20, instruction width; fields below are fixed for 20.
REG_ADDR_W, 2, regfile index width (4 registers).
IMM_W, 8, offset field width, equal to DATA_WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  instruction present.
instr  in  INSTR_WIDTH  instruction word.
instr_ready  out  1  high in IDLE only.
rs_a  out  REG_ADDR_W  regfile read port A index.
rs_b  out  REG_ADDR_W  regfile read port B index.
rd  out  REG_ADDR_W  regfile write index.
rf_we  out  1  regfile write strobe.
alu_op  out  1  0 = add, 1 = sub.
alu_src_imm  out  1  ALU operand B = imm instead of rs_b data.
imm  out  IMM_W  offset field.
dmem_re  out  1  data-memory read strobe.
dmem_we  out  1  data-memory write strobe.
wb_sel_mem  out  1  writeback source is memory read data.
done  out  1  one-cycle pulse when an instruction retires.
illegal  out  1  one-cycle pulse, coincident with done, for an undefined instruction.

Behaviour:
Field decode on the latched word:
- op = [19:18]: 00 NOP, 01 R-type, 10 LOAD_R, 11 STORE_R.
- X1 = [17:16], X2 = [15:14], X3 = [13:12], imm = [11:4], func = [3:0].

Handshake and latching:
- Transfer occurs when instr_valid && instr_ready on a rising edge; the word is latched into an internal register.
- instr may change freely after the transfer.

Reset:
- State returns to IDLE immediately, including mid-instruction.
- All strobes, done and illegal go to 0; instr_ready = 1.
- Address outputs and imm go to 0; the latched word clears to 0.
- No partial write survives reset.

States and transitions:
- IDLE: advances to DECODE on transfer.
- DECODE: drives rs_a, rs_b, rd and imm from the latch; no strobes.
  - NOP goes to IDLE with done.
  - R-type with func > 1 goes to IDLE with done and illegal.
  - All other instructions go to EXEC.
- EXEC: for R-type, rs_a = X2, rs_b = X3, alu_op = func[0], alu_src_imm = 0. For LOAD_R/STORE_R, rs_a = X2, alu_src_imm = 1, alu_op = 0. Next state is WB for R-type, MEM otherwise.
- MEM:
  - LOAD_R: dmem_re = 1, then go to WB.
  - STORE_R: dmem_we = 1 for exactly one cycle with rs_b = X1 (store data), done pulses in the same cycle, then go to IDLE.
- WB: rf_we = 1 and rd = X1. wb_sel_mem = 1 for LOAD_R, 0 for R-type. done pulses; then go to IDLE.

Latency and throughput:
- Handshake to done: NOP 1 cycle, R-type 3, STORE_R 3, LOAD_R 4.
- instr_ready re-asserts the cycle after done. No pipelining.

Output and arithmetic rules:
- Address outputs hold their last value outside the states that drive them.
- rd = X1 even when X1 equals X2 or X3; read-before-write is the datapath's concern.
- The controller never adds; effective-address truncation to 5 bits is done by the datapath.

Optional Feature:
CPU_SEQ_PERF_EN:
- Defined: adds outputs retired_cnt[15:0] and cycle_cnt[15:0].
  - retired_cnt increments on each done, including illegal.
  - cycle_cnt increments every non-IDLE cycle.
  - Both wrap at 16'hFFFF to 0 and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package cpu_seq_pkg holds:
  - typedef enum for state: IDLE, DECODE, EXEC, MEM, WB.
  - typedef enum for op: NOP, RTYPE, LOAD_R, STORE_R.
  - localparams for field bit positions and FUNC_ADD = 0, FUNC_SUB = 1.
- Sub-module cpu_seq_decode: purely combinational field extraction and legality check. The FSM stays in the top module.

Test Plan:
- Reset, then instr 20'b01000111000000000000 (ADD r0 = r1 + r3) -> ready low 3 cycles; EXEC: rs_a = 1, rs_b = 3, alu_op = 0; WB: rf_we = 1, rd = 0, wb_sel_mem = 0; done at cycle 3.
- SUB 20'b01110010000000000001 -> EXEC: alu_op = 1, rs_a = 0, rs_b = 2; WB: rd = 3.
- STORE_R 20'b11011000000011110000 -> EXEC: imm = 15, rs_a = 2, alu_src_imm = 1; MEM: dmem_we = 1 for one cycle, rs_b = 1; rf_we never asserts; done at cycle 3.
- LOAD_R 20'b10111000000011110000 -> MEM: dmem_re = 1; WB: rf_we = 1, rd = 3, wb_sel_mem = 1; done at cycle 4.
- R-type with func = 4'h5, and NOP 20'h00000 -> illegal + done at cycle 1 for the R-type; NOP gives done only; neither asserts any strobe.
- Assert rst during MEM of a STORE_R -> dmem_we drops immediately, state is IDLE, instr_ready = 1; a next ADD completes normally. With CPU_SEQ_PERF_EN, both counters read 0 after reset.
